// File: rtl/freq_calc.sv
// freq_calc: converts a gated {clk_cnt, sig_cnt} count pair into a frequency in Hz.
//   freq_hz = sig_cnt * CLK_FREQ_HZ / clk_cnt
// The multiply takes one cycle and is followed by a 64-iteration restoring divider.
// The result is presented on a valid/ready handshake together with saturation and
// divide-by-zero qualifiers.
// Optional build macro FREQ_CALC_ROUND_EN: adds clk_cnt/2 to the numerator so the
// quotient rounds half-up to the nearest Hz. When it is undefined, the quotient
// truncates toward zero.
module freq_calc #(
  parameter logic [31:0] CLK_FREQ_HZ = 32'd100_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_wr_en_i,
  input  logic [63:0] reg_wr_data_i,
  output logic        freq_valid_o,
  input  logic        freq_ready_i,
  output logic [31:0] freq_data_o,
  output logic        sat_o,
  output logic        div0_o,
  output logic        busy_o,
  output logic        drop_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN,
    ST_HOLD
  } state_t;

  state_t      state_reg;
  logic [31:0] clk_cnt_reg;
  logic [31:0] sig_cnt_reg;
  logic [63:0] num_reg;      // dividend, shifted out MSB first
  logic [31:0] div_reg;      // divisor
  logic [63:0] rem_reg;      // remainder between iterations (always < divisor)
  logic [63:0] quo_reg;      // quotient, shifted in LSB
  logic [5:0]  iter_reg;
  logic        fin_phase_reg;
  logic [31:0] word_reg;     // output word staged before it is published
  logic        word_sat_reg;
  logic        word_div0_reg;

  logic [63:0] product;
  logic [63:0] mul_result;
  logic [64:0] rem_shift;    // 65-bit partial remainder for this iteration
  logic        rem_ge;
  logic [63:0] rem_sub;
  logic [63:0] rem_next;

  // Full 64-bit product; both operands zero-extended so nothing wraps.
  assign product = {32'd0, sig_cnt_reg} * {32'd0, CLK_FREQ_HZ};

`ifdef FREQ_CALC_ROUND_EN
  // Half the divisor is added so the truncating divide rounds half-up.
  // (2^32-1)^2 + 2^31 still fits in 64 bits, so this cannot overflow.
  assign mul_result = product + {33'd0, clk_cnt_reg[31:1]};
`else
  assign mul_result = product;
`endif

  // One restoring-division step: shift in the next dividend bit and subtract if it fits.
  // When the subtraction is taken the result is below the divisor, so the low 64 bits
  // of the difference are exact.
  always_comb begin
    rem_shift = {rem_reg, num_reg[63]};
    rem_ge    = (rem_shift >= {33'd0, div_reg});
    rem_sub   = rem_shift[63:0] - {32'd0, div_reg};
    rem_next  = rem_ge ? rem_sub : rem_shift[63:0];
  end

  assign busy_o = (state_reg != ST_IDLE);

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      clk_cnt_reg   <= 32'd0;
      sig_cnt_reg   <= 32'd0;
      num_reg       <= 64'd0;
      div_reg       <= 32'd0;
      rem_reg       <= 64'd0;
      quo_reg       <= 64'd0;
      iter_reg      <= 6'd0;
      fin_phase_reg <= 1'b0;
      word_reg      <= 32'd0;
      word_sat_reg  <= 1'b0;
      word_div0_reg <= 1'b0;
      freq_valid_o  <= 1'b0;
      freq_data_o   <= 32'd0;
      sat_o         <= 1'b0;
      div0_o        <= 1'b0;
      drop_o        <= 1'b0;
    end else begin
      // Any strobe outside IDLE is discarded and flagged for one cycle.
      drop_o <= reg_wr_en_i && (state_reg != ST_IDLE);

      case (state_reg)
        ST_IDLE: begin
          if (reg_wr_en_i) begin
            clk_cnt_reg <= reg_wr_data_i[63:32];
            sig_cnt_reg <= reg_wr_data_i[31:0];
            state_reg   <= ST_MUL;
          end
        end

        ST_MUL: begin
          num_reg   <= mul_result;
          div_reg   <= clk_cnt_reg;
          rem_reg   <= 64'd0;
          quo_reg   <= 64'd0;
          iter_reg  <= 6'd0;
          state_reg <= ST_DIV;
        end

        ST_DIV: begin
          // A zero divisor still runs all iterations so latency never varies.
          num_reg  <= {num_reg[62:0], 1'b0};
          rem_reg  <= rem_next;
          quo_reg  <= {quo_reg[62:0], rem_ge};
          iter_reg <= iter_reg + 6'd1;
          if (iter_reg == 6'd63) begin
            state_reg <= ST_FIN;
          end
        end

        ST_FIN: begin
          // First cycle builds the word from the quotient; second publishes it with valid.
          if (!fin_phase_reg) begin
            fin_phase_reg <= 1'b1;
            if (clk_cnt_reg == 32'd0) begin
              word_reg      <= 32'd0;
              word_sat_reg  <= 1'b0;
              word_div0_reg <= 1'b1;
            end else if (quo_reg[63:32] != 32'd0) begin
              word_reg      <= 32'hFFFF_FFFF;
              word_sat_reg  <= 1'b1;
              word_div0_reg <= 1'b0;
            end else begin
              word_reg      <= quo_reg[31:0];
              word_sat_reg  <= 1'b0;
              word_div0_reg <= 1'b0;
            end
          end else begin
            fin_phase_reg <= 1'b0;
            freq_data_o   <= word_reg;
            sat_o         <= word_sat_reg;
            div0_o        <= word_div0_reg;
            freq_valid_o  <= 1'b1;
            state_reg     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Data and qualifiers stay as they are after the handshake.
          if (freq_valid_o && freq_ready_i) begin
            freq_valid_o <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc: randomized and directed checks of freq_calc against an arithmetic model.
module tb_freq_calc;

  localparam logic [31:0] CLKF = 32'd100_000_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] wdata;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        sat;
  logic        div0;
  logic        busy;
  logic        drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  freq_calc #(.CLK_FREQ_HZ(CLKF)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .reg_wr_en_i  (en),
    .reg_wr_data_i(wdata),
    .freq_valid_o (valid),
    .freq_ready_i (ready),
    .freq_data_o  (data),
    .sat_o        (sat),
    .div0_o       (div0),
    .busy_o       (busy),
    .drop_o       (drop)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the frequency formula.
  function automatic void ref_calc(input logic [31:0] c, input logic [31:0] s,
                                   output logic [31:0] d, output logic st, output logic dz);
    logic [63:0] num;
    logic [63:0] q;
    st = 1'b0;
    dz = 1'b0;
    d  = 32'd0;
    if (c == 32'd0) begin
      dz = 1'b1;
    end else begin
      num = {32'd0, s} * {32'd0, CLKF};
`ifdef FREQ_CALC_ROUND_EN
      num = num + {32'd0, c / 2};
`endif
      q = num / {32'd0, c};
      if (q > 64'h0000_0000_FFFF_FFFF) begin
        d  = 32'hFFFF_FFFF;
        st = 1'b1;
      end else begin
        d = q[31:0];
      end
    end
  endfunction

  // One transaction: strobe, optional dropped strobe while busy, wait for valid, accept.
  task automatic run_txn(input string tag, input logic [31:0] c, input logic [31:0] s,
                         input int inj_at, input int ready_delay);
    logic [31:0] ed;
    logic        es;
    logic        ez;
    int          lat;
    ref_calc(c, s, ed, es, ez);
    en    = 1'b1;
    wdata = {c, s};
    @(posedge clk); #1;
    en = 1'b0;
    check_val($sformatf("%s.drop_on_accept", tag), drop, 0);
    lat = 0;
    while (1) begin
      if (lat == inj_at) begin
        en    = 1'b1;
        wdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check_val($sformatf("%s.busy", tag), busy, 1);
      if (en) begin
        en = 1'b0;
        check_val($sformatf("%s.drop", tag), drop, 1);
      end
      if (valid || lat >= 200) break;
    end
    check_val($sformatf("%s.lat", tag), lat, 67);
    check_val($sformatf("%s.data", tag), data, ed);
    check_val($sformatf("%s.sat", tag), sat, es);
    check_val($sformatf("%s.div0", tag), div0, ez);
    $display("txn %s clk=%0d sig=%0d data=%0d sat=%0b div0=%0b lat=%0d", tag, c, s, data, sat, div0, lat);
    repeat (ready_delay) begin
      @(posedge clk); #1;
    end
    if (ready_delay > 0) check_val($sformatf("%s.valid_held", tag), valid, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check_val($sformatf("%s.valid_drop", tag), valid, 0);
    check_val($sformatf("%s.idle", tag), busy, 0);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] ed;
    logic        es;
    logic        ez;
    int          lat;
    int          changes;
    int          vcount;

    rst_n = 1'b0;
    en    = 1'b0;
    wdata = 64'd0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.valid", valid, 0);
    check_val("rst.data", data, 0);
    check_val("rst.sat", sat, 0);
    check_val("rst.div0", div0, 0);
    check_val("rst.busy", busy, 0);
    check_val("rst.drop", drop, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner values.
    run_txn("t1", 32'd100_000_000, 32'd1000, -1, 0);
    run_txn("t2", 32'd3, 32'd2, -1, 1);
    run_txn("t3sat", 32'd1, 32'hFFFF_FFFF, -1, 0);
    run_txn("t3div0", 32'd0, 32'd5, -1, 2);

    // Randomized pairs across regions: zero divisor, tiny divisor, near CLKF, full range.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 32'd0;
        1:       c = $urandom_range(1, 16);
        2:       c = CLKF - 32'd500 + $urandom_range(0, 1000);
        default: c = $urandom;
      endcase
      s = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 200_000);
      run_txn($sformatf("rnd%0d", i), c, s,
              ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 60),
              $urandom_range(0, 3));
    end

    // Long backpressure with a strobe during HOLD, then handshake plus strobe together.
    c = 32'd33_333_333;
    s = 32'd12345;
    ref_calc(c, s, ed, es, ez);
    en    = 1'b1;
    wdata = {c, s};
    @(posedge clk); #1;
    en  = 1'b0;
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("t4.lat", lat, 67);
    changes = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == 100) en = 1'b1;
      @(posedge clk); #1;
      if (k == 100) begin
        en = 1'b0;
        check_val("t4.hold_drop", drop, 1);
      end
      if (data !== ed || valid !== 1'b1) changes++;
    end
    check_val("t4.stable", changes, 0);
    check_val("t4.data", data, ed);
    check_val("t4.busy", busy, 1);
    $display("txn t4 held 200 cycles data=%0d", data);
    ready = 1'b1;
    en    = 1'b1;
    wdata = {32'd10, 32'd10};
    @(posedge clk); #1;
    ready = 1'b0;
    en    = 1'b0;
    check_val("t4.hs_drop", drop, 1);
    check_val("t4.hs_valid", valid, 0);
    check_val("t4.hs_busy", busy, 0);
    @(posedge clk); #1;
    check_val("t4.not_started", busy, 0);

    // Reset in the middle of the divide.
    en    = 1'b1;
    wdata = {32'd1000, 32'd3};
    @(posedge clk); #1;
    en = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("t5.valid", valid, 0);
    check_val("t5.data", data, 0);
    check_val("t5.sat", sat, 0);
    check_val("t5.div0", div0, 0);
    check_val("t5.busy", busy, 0);
    vcount = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (valid || busy) vcount++;
    end
    check_val("t5.quiet", vcount, 0);
    $display("txn t5 reset mid-divide");
    run_txn("t5b", 32'd1000, 32'd3, -1, 0);

    // Ready tied high: valid lasts exactly one cycle.
    ready = 1'b1;
    en    = 1'b1;
    wdata = {32'd1_000_000, 32'd7};
    @(posedge clk); #1;
    en  = 1'b0;
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("t6.lat", lat, 67);
    check_val("t6.data", data, 700);
    @(posedge clk); #1;
    check_val("t6.one_cycle", valid, 0);
    ready = 1'b0;
    $display("txn t6 clk=1000000 sig=7 data=%0d", data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
